irq_event_arbiter: RTL

//  Collects the three game-event sources (PS2 key pulse, VGA frame sync, pipe refresh)
//  and serialises them into a single interrupt channel for the processor.

---
 rtl/irq_event_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/irq_event_arbiter.sv
// irq_event_arbiter: serialises key, VGA frame-sync and pipe-refresh events
// onto a single valid/ack interrupt channel. Key codes are queued in a small
// FIFO. Sync and refresh edges are coalesced into saturating counts.
// Optional build macro IRQ_ARB_RR_EN selects round-robin grant. When it is not
// defined, grant order is fixed priority: key > vga > pipe.
module irq_event_arbiter #(
  parameter int KEY_FIFO_DEPTH = 4,
  parameter int KEY_W          = 8,
  parameter int CNT_W          = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             key_int,
  input  logic [KEY_W-1:0] key_data,
  input  logic             vga_int,
  input  logic             pipe_int,
  input  logic             irq_ack,
  output logic             irq_valid,
  output logic [1:0]       irq_id,
  output logic [KEY_W-1:0] irq_data,
  output logic [2:0]       pending,
  output logic [CNT_W-1:0] overflow_cnt
);

  localparam int PTR_W = $clog2(KEY_FIFO_DEPTH);
  localparam logic [PTR_W:0]   PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {S_IDLE, S_PRESENT} state_e;

  state_e           state_q, state_d;
  logic             irq_valid_q, irq_valid_d;
  logic [1:0]       irq_id_q, irq_id_d;
  logic [KEY_W-1:0] irq_data_q, irq_data_d;
  logic [2:0]       pending_q, pending_d;
  logic [CNT_W-1:0] overflow_cnt_q, overflow_cnt_d;
  logic [CNT_W-1:0] cnt_vga_q, cnt_vga_d;
  logic [CNT_W-1:0] cnt_pipe_q, cnt_pipe_d;
  logic             vga_prev_q, vga_prev_d;
  logic             pipe_prev_q, pipe_prev_d;
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [KEY_W-1:0] fifo_mem_q [KEY_FIFO_DEPTH];

  logic ev_vga, ev_pipe;
  logic fifo_empty, fifo_full;
  logic push_ok, drop, pop;
  logic grant_key, grant_vga, grant_pipe;

`ifdef IRQ_ARB_RR_EN
  // Last granted source: 0 key, 1 vga, 2 pipe.
  logic [1:0] rr_ptr_q, rr_ptr_d;
`endif

  assign irq_valid    = irq_valid_q;
  assign irq_id       = irq_id_q;
  assign irq_data     = irq_data_q;
  assign pending      = pending_q;
  assign overflow_cnt = overflow_cnt_q;

  // Pick at most one source to grant while idle, using the registered pending vector.
  always_comb begin
    grant_key  = 1'b0;
    grant_vga  = 1'b0;
    grant_pipe = 1'b0;
    if (state_q == S_IDLE) begin
`ifdef IRQ_ARB_RR_EN
      case (rr_ptr_q)
        2'd0: begin
          if (pending_q[1])      grant_vga  = 1'b1;
          else if (pending_q[2]) grant_pipe = 1'b1;
          else if (pending_q[0]) grant_key  = 1'b1;
        end
        2'd1: begin
          if (pending_q[2])      grant_pipe = 1'b1;
          else if (pending_q[0]) grant_key  = 1'b1;
          else if (pending_q[1]) grant_vga  = 1'b1;
        end
        default: begin
          if (pending_q[0])      grant_key  = 1'b1;
          else if (pending_q[1]) grant_vga  = 1'b1;
          else if (pending_q[2]) grant_pipe = 1'b1;
        end
      endcase
`else
      if (pending_q[0])      grant_key  = 1'b1;
      else if (pending_q[1]) grant_vga  = 1'b1;
      else if (pending_q[2]) grant_pipe = 1'b1;
`endif
    end
  end

`ifdef IRQ_ARB_RR_EN
  // Remember the most recent grant so the next search starts just after it.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_key)       rr_ptr_d = 2'd0;
    else if (grant_vga)  rr_ptr_d = 2'd1;
    else if (grant_pipe) rr_ptr_d = 2'd2;
  end
`endif

  // Edge detection, event coalescing, key FIFO control and pending summary.
  always_comb begin
    vga_prev_d  = vga_int;
    pipe_prev_d = pipe_int;
    ev_vga      = vga_int & ~vga_prev_q;
    ev_pipe     = pipe_int & ~pipe_prev_q;

    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                 (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    pop        = grant_key;
    push_ok    = key_int & (~fifo_full | pop);
    drop       = key_int & fifo_full & ~pop;

    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    overflow_cnt_d = overflow_cnt_q;
    if (drop && (overflow_cnt_q != CNT_MAX)) overflow_cnt_d = overflow_cnt_q + CNT_ONE;

    cnt_vga_d = cnt_vga_q;
    if (grant_vga)                            cnt_vga_d = ev_vga ? CNT_ONE : '0;
    else if (ev_vga && (cnt_vga_q != CNT_MAX)) cnt_vga_d = cnt_vga_q + CNT_ONE;

    cnt_pipe_d = cnt_pipe_q;
    if (grant_pipe)                             cnt_pipe_d = ev_pipe ? CNT_ONE : '0;
    else if (ev_pipe && (cnt_pipe_q != CNT_MAX)) cnt_pipe_d = cnt_pipe_q + CNT_ONE;

    pending_d = {(cnt_pipe_q != '0), (cnt_vga_q != '0), ~fifo_empty};
  end

  // Present/acknowledge FSM: load the granted event, hold it until acked.
  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    irq_data_d  = irq_data_q;
    case (state_q)
      S_IDLE: begin
        if (grant_key) begin
          irq_valid_d = 1'b1;
          irq_id_d    = 2'd1;
          irq_data_d  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
          state_d     = S_PRESENT;
        end else if (grant_vga) begin
          irq_valid_d = 1'b1;
          irq_id_d    = 2'd2;
          irq_data_d  = KEY_W'(cnt_vga_q);
          state_d     = S_PRESENT;
        end else if (grant_pipe) begin
          irq_valid_d = 1'b1;
          irq_id_d    = 2'd3;
          irq_data_d  = KEY_W'(cnt_pipe_q);
          state_d     = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (irq_ack) begin
          irq_valid_d = 1'b0;
          irq_id_d    = 2'd0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      irq_valid_q    <= 1'b0;
      irq_id_q       <= 2'd0;
      irq_data_q     <= '0;
      pending_q      <= 3'd0;
      overflow_cnt_q <= '0;
      cnt_vga_q      <= '0;
      cnt_pipe_q     <= '0;
      vga_prev_q     <= 1'b0;
      pipe_prev_q    <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
`ifdef IRQ_ARB_RR_EN
      rr_ptr_q       <= 2'd2;
`endif
    end else begin
      state_q        <= state_d;
      irq_valid_q    <= irq_valid_d;
      irq_id_q       <= irq_id_d;
      irq_data_q     <= irq_data_d;
      pending_q      <= pending_d;
      overflow_cnt_q <= overflow_cnt_d;
      cnt_vga_q      <= cnt_vga_d;
      cnt_pipe_q     <= cnt_pipe_d;
      vga_prev_q     <= vga_prev_d;
      pipe_prev_q    <= pipe_prev_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
`ifdef IRQ_ARB_RR_EN
      rr_ptr_q       <= rr_ptr_d;
`endif
    end
  end

  // Key-code storage; entries are cleared on reset so nothing stale survives.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < KEY_FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else if (push_ok) begin
      fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= key_data;
    end
  end

endmodule
